bus_sync_hs: RTL
================

# bus_sync_hs

Destination-side bus synchronizer that moves a multi-bit word from a foreign clock domain into the `CLK` domain using a toggle request/acknowledge handshake. It sits directly downstream of the reset synchronizer: its `RST` is that synchronizer's `SYNC_RST` output for the destination domain. It delivers a stable `SYNC_BUS` word plus a one-cycle `ENABLE_PULSE` to local consumers, with consumer backpressure.

## Interface
- `NUM_STAGES`, default 2: flops in the request synchronizer chain; legal range ≥2.
- `BUS_WIDTH`, default 8: data word width.
- `CLK`  in  1: destination-domain clock.
- `RST`  in  1: asynchronous, active-low reset, driven from the destination domain's synchronized reset.
- `UNSYNC_BUS`  in  BUS_WIDTH: source-domain data. The source holds it stable from its `BUS_REQ` toggle until it sees the matching `BUS_ACK`.
- `BUS_REQ`  in  1: source-domain request toggle. Each transition announces one new word.
- `DST_READY`  in  1: local consumer can accept a word this cycle.
- `SYNC_BUS`  out  BUS_WIDTH: registered captured word, stable between captures.
- `ENABLE_PULSE`  out  1: registered one-cycle strobe, high when `SYNC_BUS` is handed to the consumer.
- `BUS_ACK`  out  1: registered ack toggle returned to the source; equals the last accepted request level.
- `PROTO_ERR`  out  1: sticky flag for a handshake violation.

## Operation
- `BUS_REQ` passes through a `NUM_STAGES` flop chain, producing `req_s`.
- Register `req_seen` holds the last accepted request level. A new word is pending when `req_s != req_seen`.
- The FSM has two states, IDLE and PEND.
  - IDLE: on a new-word condition, capture `UNSYNC_BUS` into `SYNC_BUS`, latch `req_pend <= req_s`, go to PEND.
  - PEND: if `DST_READY`=1, set `ENABLE_PULSE`=1 for one cycle, `BUS_ACK <= req_pend`, `req_seen <= req_pend`, go to IDLE. Otherwise hold PEND with `SYNC_BUS` unchanged.
- Violation: in PEND, if `req_s != req_pend`, set `PROTO_ERR`=1. The source toggled again before being acked. The current word is still delivered normally; the extra toggle is seen as a new word after return to IDLE. `PROTO_ERR` clears only on reset.
- `ENABLE_PULSE` is never high on two consecutive cycles.
- Reset values: `SYNC_BUS`=0, `ENABLE_PULSE`=0, `BUS_ACK`=0, `PROTO_ERR`=0, synchronizer chain=0, `req_seen`=0, `req_pend`=0, state=IDLE.
- Reset mid-operation: any pending word is discarded and no pulse is emitted. The source domain must be reset with its request at 0 so both sides restart at level 0.

## Timing
All edges below are `CLK` rising edges. Edge 1 is the first edge that samples a toggled `BUS_REQ`.
- `req_s` reflects the toggle after edge `NUM_STAGES`.
- Capture happens at edge `NUM_STAGES+1`: `SYNC_BUS` is updated and state is PEND.
- If `DST_READY`=1 at edge `NUM_STAGES+2`, `ENABLE_PULSE` and the `BUS_ACK` toggle appear after that edge.
- Default latency from request to pulse is 4 edges.
- Each cycle `DST_READY`=0 in PEND adds one cycle.
- A request already pending in `req_s` when FSM returns to IDLE is captured on the next edge. Minimum spacing between pulses is 2 cycles.
- `SYNC_BUS` changes only on capture edges, never while `ENABLE_PULSE`=1.

## Structure
- Shared package: the FSM state enum (IDLE, PEND) and `NUM_STAGES`/`BUS_WIDTH` defaults.
- One sub-module, `bit_sync`: an N-stage single-bit synchronizer with async active-low reset, reusable elsewhere in the design. It is instantiated once for `BUS_REQ`.
- The data path is a plain capture register. It is never run through the synchronizer.

## Test plan
- Reset then idle: `RST` low, then high, no toggle → all outputs 0 for 20 cycles.
- Single word: `UNSYNC_BUS`=0xA5, `BUS_REQ` 0→1, `DST_READY`=1 → `SYNC_BUS`=0xA5 after edge 3, `ENABLE_PULSE` high for 1 cycle after edge 4, `BUS_ACK`=1.
- Backpressure: word 0x3C with `DST_READY`=0 for 5 cycles, then 1 → pulse delayed 5 cycles, `SYNC_BUS` held at 0x3C throughout, exactly 1 pulse.
- Stream of 4 words 0x01..0x04, each toggle sent after the previous `BUS_ACK` → 4 pulses with `SYNC_BUS` values 0x01..0x04 in order, `BUS_ACK` ending at 0, `PROTO_ERR`=0.
- Violation: toggle `BUS_REQ` twice while in PEND with `DST_READY`=0 → `PROTO_ERR`=1 sticky, first word still pulsed once.
- Reset in PEND: assert `RST` while a word is waiting on `DST_READY`=0 → no pulse, all outputs 0, and a fresh word after release is delivered normally.

Source files
------------

// File: rtl/bus_sync_hs_pkg.sv
// Shared types and default sizes for the toggle-handshake bus synchronizer.
// Imported by the synchronizer top and anything that inspects its FSM.
package bus_sync_hs_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } hs_state_t;

    localparam int DEF_NUM_STAGES = 2;
    localparam int DEF_BUS_WIDTH  = 8;

endpackage : bus_sync_hs_pkg

// File: rtl/bus_sync_hs_bit_sync.sv
// N-stage single-bit synchronizer with asynchronous active-low reset.
// Generic building block; only the MSB of the chain is safe to use downstream.
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [NUM_STAGES-1:0] r_chain;

    // shift the asynchronous input through the metastability chain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[NUM_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[NUM_STAGES-1];

endmodule : bit_sync

// File: rtl/bus_sync_hs.sv
// Destination-side toggle req/ack bus synchronizer with consumer backpressure.
// The word is captured directly from UNSYNC_BUS once the request toggle has settled.
module bus_sync_hs
    import bus_sync_hs_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_REQ,
    input  logic                 DST_READY,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 BUS_ACK,
    output logic                 PROTO_ERR
);

    logic                 w_req_s;
    hs_state_t            r_state;
    logic                 r_req_seen;
    logic                 r_req_pend;
    logic [BUS_WIDTH-1:0] r_sync_bus;
    logic                 r_pulse;
    logic                 r_ack;
    logic                 r_err;

    bit_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_req_sync (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_d     (BUS_REQ),
        .o_q     (w_req_s)
    );

    // handshake FSM: capture on a new request level, hand off when the consumer is ready
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_req_seen <= 1'b0;
            r_req_pend <= 1'b0;
            r_sync_bus <= '0;
            r_pulse    <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_s != r_req_seen) begin
                        r_sync_bus <= UNSYNC_BUS;
                        r_req_pend <= w_req_s;
                        r_state    <= ST_PEND;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_PEND: begin
                    // a further toggle before our ack is a source-side protocol breach
                    if (w_req_s != r_req_pend) begin
                        r_err <= 1'b1;
                    end else begin
                        r_err <= r_err;
                    end
                    if (DST_READY) begin
                        r_pulse    <= 1'b1;
                        r_ack      <= r_req_pend;
                        r_req_seen <= r_req_pend;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_state    <= ST_PEND;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign SYNC_BUS     = r_sync_bus;
    assign ENABLE_PULSE = r_pulse;
    assign BUS_ACK      = r_ack;
    assign PROTO_ERR    = r_err;

endmodule : bus_sync_hs
